// File: rtl/axis_width_conv_lcm.sv
// N-bit to M-bit stream width converter through a ring of LCM(N,M)-bit pages.
// Pages are packed MSB-first; a mid-page tfirst drops the partial page.
module axis_width_conv_lcm #(
  parameter int N     = 4,
  parameter int M     = 6,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         s_axis_tnext,
  input  logic [N-1:0] s_axis_tdata,
  input  logic         s_axis_tfirst,
  input  logic         s_axis_tvalid,
  input  logic         m_axis_tnext,
  output logic [M-1:0] m_axis_tdata,
  output logic         m_axis_tfirst,
  output logic         m_axis_tvalid,
  output logic         frame_error,
  output logic [15:0]  bit_count
);

  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  localparam int LCM = (N / gcd(N, M)) * M;
  localparam int KN  = LCM / N;
  localparam int KM  = LCM / M;
  localparam int PW  = $clog2(DEPTH);
  localparam int IW  = (KN > 1) ? $clog2(KN) : 1;
  localparam int OW  = (KM > 1) ? $clog2(KM) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [LCM-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pfirst;
  logic [PW-1:0]  wr_page;
  logic [PW-1:0]  rd_page;
  logic [IW-1:0]  wr_idx;
  logic [OW-1:0]  rd_idx;
  logic [CW-1:0]  occ;

  logic           wr_en;
  logic           rd_en;
  logic           resync;
  logic           commit;
  logic           release_pg;
  logic [IW-1:0]  eff_idx;
  logic [31:0]    bc_full;

  assign s_axis_tnext  = s_axis_tvalid && (occ != CW'(DEPTH)) && !rst;
  assign m_axis_tvalid = (occ != '0);
  assign m_axis_tdata  = mem[rd_page][LCM-1-int'(rd_idx)*M -: M];
  assign m_axis_tfirst = pfirst[rd_page] && (rd_idx == '0);

  // Handshake decode; a tfirst chunk always lands in slot 0 of the page
  always_comb begin
    wr_en      = s_axis_tnext;
    rd_en      = m_axis_tnext && m_axis_tvalid;
    eff_idx    = s_axis_tfirst ? '0 : wr_idx;
    resync     = wr_en && s_axis_tfirst && (wr_idx != '0);
    commit     = wr_en && (eff_idx == IW'(KN - 1));
    release_pg = rd_en && (rd_idx == OW'(KM - 1));
  end

  // Held bits, computed wide and saturated to 16 bits
  always_comb begin
    bc_full = 32'(occ) * 32'(LCM)
            + 32'(wr_idx) * 32'(N)
            - 32'(rd_idx) * 32'(M);
    bit_count = (bc_full > 32'hFFFF) ? 16'hFFFF : bc_full[15:0];
  end

  // Page storage and per-page frame-start flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pfirst <= '0;
    end else if (wr_en) begin
      mem[wr_page][LCM-1-int'(eff_idx)*N -: N] <= s_axis_tdata;
      if (eff_idx == '0) pfirst[wr_page] <= s_axis_tfirst;
    end
  end

  // Write-side chunk index and page pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_page <= '0;
    end else if (wr_en) begin
      if (commit) begin
        wr_idx  <= '0;
        wr_page <= wr_page + PW'(1);
      end else begin
        wr_idx  <= eff_idx + IW'(1);
      end
    end
  end

  // Read-side chunk index and page pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx  <= '0;
      rd_page <= '0;
    end else if (rd_en) begin
      if (release_pg) begin
        rd_idx  <= '0;
        rd_page <= rd_page + PW'(1);
      end else begin
        rd_idx  <= rd_idx + OW'(1);
      end
    end
  end

  // Committed page count; commit and release together cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else if (commit && !release_pg) begin
      occ <= occ + CW'(1);
    end else if (release_pg && !commit) begin
      occ <= occ - CW'(1);
    end
  end

  // One-cycle pulse for each discarded partial page
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_error <= 1'b0;
    else     frame_error <= resync;
  end

endmodule

// File: tb/tb_axis_width_conv_lcm.sv
// Randomized scoreboard bench for axis_width_conv_lcm (4->6, plus an 8->4 instance).
// Reference model keeps a bit queue of the partial page and a queue of expected chunks.
module tb_axis_width_conv_lcm;

  localparam int N = 4;
  localparam int M = 6;
  localparam int DEPTH = 2;
  localparam int LCM = 12;
  localparam int KM = LCM / M;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         s_tnext;
  logic [N-1:0] s_tdata = '0;
  logic         s_tfirst = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         m_tnext = 1'b0;
  logic [M-1:0] m_tdata;
  logic         m_tfirst;
  logic         m_tvalid;
  logic         fe;
  logic [15:0]  bc;

  logic         w_stnext;
  logic [7:0]   w_sdata = '0;
  logic         w_sfirst = 1'b0;
  logic         w_svalid = 1'b0;
  logic         w_mnext = 1'b0;
  logic [3:0]   w_mdata;
  logic         w_mfirst;
  logic         w_mvalid;
  logic         w_fe;
  logic [15:0]  w_bc;

  axis_width_conv_lcm #(.N(N), .M(M), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tnext(s_tnext), .s_axis_tdata(s_tdata),
    .s_axis_tfirst(s_tfirst), .s_axis_tvalid(s_tvalid),
    .m_axis_tnext(m_tnext), .m_axis_tdata(m_tdata),
    .m_axis_tfirst(m_tfirst), .m_axis_tvalid(m_tvalid),
    .frame_error(fe), .bit_count(bc)
  );

  axis_width_conv_lcm #(.N(8), .M(4), .DEPTH(2)) u_w (
    .clk(clk), .rst(rst),
    .s_axis_tnext(w_stnext), .s_axis_tdata(w_sdata),
    .s_axis_tfirst(w_sfirst), .s_axis_tvalid(w_svalid),
    .m_axis_tnext(w_mnext), .m_axis_tdata(w_mdata),
    .m_axis_tfirst(w_mfirst), .m_axis_tvalid(w_mvalid),
    .frame_error(w_fe), .bit_count(w_bc)
  );

  typedef struct {
    logic [M-1:0] d;
    logic         f;
    logic         last;
  } exp_t;

  int tests = 0;
  int fails = 0;

  exp_t         expq[$];
  logic [M-1:0] out_log[$];
  bit           part[$];
  logic         part_first = 1'b0;
  int           pages_held = 0;
  int           held_bits = 0;
  logic         fe_exp = 1'b0;
  exp_t         e;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_accept(input logic [N-1:0] d, input logic f);
    exp_t x;
    logic [M-1:0] c;
    if (f && part.size() != 0) begin
      held_bits -= part.size();
      part.delete();
      fe_exp = 1'b1;
    end
    if (part.size() == 0) part_first = f;
    for (int i = N - 1; i >= 0; i--) part.push_back(d[i]);
    held_bits += N;
    if (part.size() == LCM) begin
      for (int k = 0; k < KM; k++) begin
        for (int j = 0; j < M; j++) c[M-1-j] = part[k*M + j];
        x.d = c;
        x.f = part_first && (k == 0);
        x.last = (k == KM - 1);
        expq.push_back(x);
      end
      part.delete();
      pages_held++;
    end
  endtask

  task automatic model_clear();
    part.delete();
    expq.delete();
    pages_held = 0;
    held_bits = 0;
    fe_exp = 1'b0;
  endtask

  // One clock: drive, check registered state, then commit acceptance to model
  task automatic cyc(input logic v, input logic [N-1:0] d, input logic f,
                     input logic mn, output logic acc);
    @(posedge clk);
    #1;
    s_tvalid = v;
    s_tdata  = d;
    s_tfirst = f;
    m_tnext  = mn;
    #1;
    chk("frame_error", 32'(fe), 32'(fe_exp));
    chk("bit_count", 32'(bc), 32'(held_bits));
    chk("s_tnext", 32'(s_tnext), 32'(v && pages_held < DEPTH));
    chk("m_tvalid", 32'(m_tvalid), 32'(pages_held != 0));
    acc = v && (pages_held < DEPTH);
    fe_exp = 1'b0;
    @(negedge clk);
    if (acc) model_accept(d, f);
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && expq.size() != 0; i++) cyc(1'b0, '0, 1'b0, 1'b1, a);
    chk("drain_empty", 32'(expq.size()), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, a);
  endtask

  // Monitor: pops an expected chunk for every output transfer
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tnext) begin
      chk("out_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("m_tdata", 32'(m_tdata), 32'(e.d));
        chk("m_tfirst", 32'(m_tfirst), 32'(e.f));
        held_bits -= M;
        if (e.last) pages_held--;
        out_log.push_back(m_tdata);
      end
    end
  end

  logic [15:0] wbc [5] = '{16'd8, 16'd4, 16'd8, 16'd4, 16'd0};
  logic        wv  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0]  wd  [4] = '{4'hA, 4'h5, 4'h3, 4'hC};
  logic        wf  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    logic a;
    int k;

    #12;
    s_tvalid = 1'b1;
    #1;
    chk("rst_tnext", 32'(s_tnext), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tfirst", 32'(m_tfirst), 32'd0);
    chk("rst_fe", 32'(fe), 32'd0);
    chk("rst_bc", 32'(bc), 32'd0);
    s_tvalid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;

    // 8 -> 4 instance: A5 then (one gap) 3C with continuous reads
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        chk("w_bc", 32'(w_bc), 32'(wbc[i-1]));
        chk("w_tvalid", 32'(w_mvalid), 32'(wv[i-1]));
        chk("w_fe", 32'(w_fe), 32'd0);
        if (i <= 4) begin
          chk("w_tdata", 32'(w_mdata), 32'(wd[i-1]));
          chk("w_tfirst", 32'(w_mfirst), 32'(wf[i-1]));
        end
      end
      w_mnext  = 1'b1;
      w_svalid = (i == 0) || (i == 2);
      w_sdata  = (i == 0) ? 8'hA5 : 8'h3C;
      w_sfirst = (i == 0);
      #1;
      chk("w_tnext", 32'(w_stnext), 32'(w_svalid));
    end
    w_svalid = 1'b0;
    w_mnext  = 1'b0;

    // Basic narrow -> wide
    out_log.delete();
    cyc(1'b1, 4'hA, 1'b1, 1'b1, a);
    cyc(1'b1, 4'hB, 1'b0, 1'b1, a);
    cyc(1'b1, 4'hC, 1'b0, 1'b1, a);
    drain();
    chk("basic_n", 32'(out_log.size()), 32'd2);
    if (out_log.size() == 2) begin
      chk("basic_0", 32'(out_log[0]), 32'h2A);
      chk("basic_1", 32'(out_log[1]), 32'h3C);
    end

    // Resync mid-page
    out_log.delete();
    cyc(1'b1, 4'h1, 1'b1, 1'b1, a);
    cyc(1'b1, 4'h2, 1'b0, 1'b1, a);
    cyc(1'b1, 4'h5, 1'b1, 1'b1, a);
    cyc(1'b1, 4'h6, 1'b0, 1'b1, a);
    chk("resync_fe_pulse", 32'(fe), 32'd1);
    cyc(1'b1, 4'h7, 1'b0, 1'b1, a);
    drain();
    chk("resync_n", 32'(out_log.size()), 32'd2);
    if (out_log.size() == 2) begin
      chk("resync_0", 32'(out_log[0]), 32'h15);
      chk("resync_1", 32'(out_log[1]), 32'h27);
    end

    // Full backpressure: 6 chunks fill both pages, 7th waits for a free page
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 4'($urandom), i == 0, 1'b0, a);
    k = -1;
    for (int i = 0; i < 10 && k < 0; i++) begin
      cyc(1'b1, 4'h9, 1'b0, (i == 1) || (i == 2), a);
      if (i == 0) chk("full_bc", 32'(bc), 32'd24);
      if (i == 2) chk("full_bc_read", 32'(bc), 32'd18);
      if (a) k = i;
    end
    chk("full_accept_cycle", 32'(k), 32'd3);
    cyc(1'b1, 4'h4, 1'b0, 1'b0, a);
    cyc(1'b1, 4'h8, 1'b0, 1'b0, a);
    drain();

    // Commit and release on the same edge
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 4'($urandom), i == 0, 1'b0, a);
    cyc(1'b0, '0, 1'b0, 1'b1, a);
    cyc(1'b1, 4'hE, 1'b0, 1'b1, a);
    cyc(1'b0, '0, 1'b0, 1'b0, a);
    chk("simul_bc", 32'(bc), 32'd12);
    chk("simul_tvalid", 32'(m_tvalid), 32'd1);
    drain();

    // Reset after two chunks
    cyc(1'b1, 4'h3, 1'b1, 1'b0, a);
    cyc(1'b1, 4'hD, 1'b0, 1'b0, a);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_tnext", 32'(s_tnext), 32'd0);
    chk("mrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mrst_tdata", 32'(m_tdata), 32'd0);
    chk("mrst_tfirst", 32'(m_tfirst), 32'd0);
    chk("mrst_bc", 32'(bc), 32'd0);
    s_tvalid = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    out_log.delete();
    cyc(1'b1, 4'hA, 1'b1, 1'b1, a);
    cyc(1'b1, 4'hB, 1'b0, 1'b1, a);
    cyc(1'b1, 4'hC, 1'b0, 1'b1, a);
    drain();
    chk("post_rst_n", 32'(out_log.size()), 32'd2);
    if (out_log.size() == 2) begin
      chk("post_rst_0", 32'(out_log[0]), 32'h2A);
      chk("post_rst_1", 32'(out_log[1]), 32'h3C);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 9) < 7, 4'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6, a);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_width_conv_lcm.md
# axis_width_conv_lcm

Generic AXI-Stream-style width converter between an N-bit and an M-bit stream, with arbitrary N and M. Neither width has to divide the other, and the block works in both narrow→wide and wide→narrow directions. Data passes through a ring of DEPTH pages of LCM(N,M) bits each, packed MSB-first. Frame alignment is tracked per page. A mid-page `tfirst` resynchronises the block by discarding the partial page, instead of stalling the input. The block sits between stream producers and consumers of mismatched width, for example between a serializer and a bus.

## Interface
- `N`, 4: input data width, ≥1.
- `M`, 6: output data width, ≥1.
- `DEPTH`, 2: number of LCM-bit pages. Power of two, ≥2.
- Derived values:
  - `LCM` = lcm(N,M), computed at elaboration.
  - `KN` = LCM/N input chunks per page.
  - `KM` = LCM/M output chunks per page.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `s_axis_tnext`  out  1  input chunk accepted this cycle.
- `s_axis_tdata`  in  N  input chunk.
- `s_axis_tfirst`  in  1  chunk is the first of a frame.
- `s_axis_tvalid`  in  1  input chunk present.
- `m_axis_tnext`  in  1  downstream consumes the current output chunk.
- `m_axis_tdata`  out  M  output chunk.
- `m_axis_tfirst`  out  1  output chunk is the first of a frame.
- `m_axis_tvalid`  out  1  output chunk present.
- `frame_error`  out  1  one-cycle pulse: a partial page was discarded.
- `bit_count`  out  16  data bits currently held.

## Operation
- **State:**
  - page memory DEPTH×LCM;
  - `wr_page`, `rd_page` (log2 DEPTH bits, wrapping);
  - `wr_idx` 0..KN-1 and `rd_idx` 0..KM-1;
  - `occ` 0..DEPTH, the number of committed pages;
  - per-page `pfirst` bit.
- **Write path:**
  - `s_axis_tnext = s_axis_tvalid && occ != DEPTH && !rst`, combinational from registered state.
  - An accepted chunk is written to bits [LCM-1-wr_idx·N -: N] of `wr_page`.
  - When `wr_idx == 0`, `pfirst[wr_page] <= s_axis_tfirst`.
  - On `wr_idx == KN-1` the page commits: `wr_idx <= 0`, `wr_page++`, `occ++`.
- **Resync:** an accepted chunk with `tfirst=1` while `wr_idx != 0`:
  - the partial page is discarded;
  - the chunk is written as chunk 0 of the same page, with `pfirst=1` and `wr_idx <= 1` (or commit if KN==1);
  - `frame_error` pulses high for the following cycle.
- **Read path:**
  - `m_axis_tvalid = (occ != 0)`.
  - `m_axis_tdata` = bits [LCM-1-rd_idx·M -: M] of `rd_page`.
  - `m_axis_tfirst = pfirst[rd_page] && rd_idx == 0`.
  - A transfer occurs when `m_axis_tnext && m_axis_tvalid`; then `rd_idx++`.
  - On `rd_idx == KM-1`: `rd_idx <= 0`, `rd_page++`, `occ--`.
  - `m_axis_tnext` while `m_axis_tvalid` is low is ignored.
- **Simultaneous commit and release:** `occ` is unchanged.
- **Bit count:** `bit_count = occ·LCM + wr_idx·N − rd_idx·M`, computed in at least 17 bits and saturated to 16'hFFFF.
- **N == M:** behaves as a DEPTH-entry FIFO. `frame_error` never fires because KN==1.

## Timing
- **Reset values:**
  - all indices, pointers and `occ` = 0;
  - memory and `pfirst` = 0;
  - `s_axis_tnext`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tfirst`=0, `frame_error`=0, `bit_count`=0.
- **Reset mid-operation:** all buffered data is lost immediately and the block is idle on the first edge after release.
- **Latency:** if the last chunk of a page is accepted at edge k, `m_axis_tvalid` is high from edge k onward. Minimum latency is one cycle and there is no combinational bypass.
- **Full:** `occ == DEPTH` holds `s_axis_tnext` low. A page freed at edge k allows acceptance in the cycle after edge k. There is no same-cycle reuse of a freed page.
- **Throughput:**
  - 1 input chunk per cycle when not full;
  - 1 output chunk per cycle when not empty;
  - both may transfer in the same cycle.
- **`frame_error`:** registered, exactly one cycle wide per resync event. Back-to-back resync events produce back-to-back pulses.

## Test plan
All scenarios use N=4, M=6, DEPTH=2 unless noted.
- **Reset mid-stream:** assert `rst` after 2 chunks → `tvalid`, `tnext`, `tdata`, `tfirst` and `bit_count` all 0 asynchronously; after release, a fresh page is converted correctly.
- **Basic narrow→wide:** 0xA(tfirst),0xB,0xC with `m_axis_tnext`=1 → output 0x2A(tfirst=1), then 0x3C(tfirst=0). `tvalid` rises one cycle after 0xC is accepted.
- **Full backpressure:** `m_axis_tnext`=0, 7 chunks offered → 6 accepted, `s_axis_tnext` low on the 7th, `bit_count`=24. One read → `bit_count`=18 and still stalled. Second read → 7th chunk accepted the next cycle.
- **Resync:** 0x1(tfirst),0x2,0x5(tfirst),0x6,0x7 → `frame_error` high one cycle after 0x5 is accepted; output 0x15(tfirst=1), 0x27; 0x1 and 0x2 never appear.
- **Simultaneous commit/release:** one page resident and one partially written; on the same edge the last input chunk is accepted and the last output chunk is read → `occ` stays 1, no chunk is lost or duplicated, and `bit_count` is consistent.
- **Wide→narrow (N=8, M=4):** input 0xA5(tfirst), 0x3C → output 0xA(tfirst),0x5,0x3,0xC; `bit_count` goes 8,4,8,4,0 under continuous reads.
